vram_write_poster: RTL

- CPU-side initiator for the video RAM write port. The video controller is the responder: it grants external access with n_rdy=0 and otherwise gates the RAM write enables.
- Captures CPU writes to 0xE000-0xFFFF into a small FIFO, so the CPU does not wait for the active-pixel window to end.
- Drains queued writes onto the video bus with a SETUP/STROBE/HOLD sequence. A strobe that loses the grant part-way is retried.
- Asserts n_cpu_wait when the FIFO is full.

---
 rtl/vram_write_poster_if.sv | 33 +++
 rtl/vram_write_poster.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vram_write_poster_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vram_write_poster_if
// Description : Video RAM write-port bus between the CPU-side poster
//               (master) and the video controller (slave).
//               bus_a    - address of the write being presented
//               bus_d    - data of the write being presented
//               bus_n_we - write strobe, active low
//               n_rdy    - grant from the video controller, 0 = access allowed
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_write_poster_if;
    logic [15:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_n_we;
    logic        n_rdy;

    modport master (
        output bus_a,
        output bus_d,
        output bus_n_we,
        input  n_rdy
    );

    modport slave (
        input  bus_a,
        input  bus_d,
        input  bus_n_we,
        output n_rdy
    );
endinterface
`default_nettype wire

// File: rtl/vram_write_poster.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vram_write_poster
// Description : Posts CPU writes aimed at video RAM (0xE000-0xFFFF) into a
//               small FIFO and drains them onto the video bus with a
//               SETUP/STROBE/HOLD sequence. A strobe whose grant is withdrawn
//               is retried. The CPU is stalled only when the FIFO is full.
// Ports       : clk, n_rst         - clock, async active-low reset
//               cpu_a/cpu_d/cpu_n_we - CPU write request
//               n_cpu_wait         - 0 = CPU must hold its write
//               vbus (master)      - video bus: bus_a, bus_d, bus_n_we, n_rdy
//               level, n_empty     - FIFO occupancy and non-empty flag
// Revision    : 1.0 - initial release
// ============================================================================
module vram_write_poster #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wire logic               clk,
    input  wire logic               n_rst,
    input  wire logic [15:0]        cpu_a,
    input  wire logic [7:0]         cpu_d,
    input  wire logic               cpu_n_we,
    output logic                    n_cpu_wait,
    vram_write_poster_if.master     vbus,
    output logic [PTR_W:0]          level,
    output logic                    n_empty
);

    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_bus_n_we;
    logic               r_prev_n_we;
    logic               r_pend;
    logic [15:0]        r_pend_a;
    logic [7:0]         r_pend_d;
    logic [23:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_level;

    logic               w_req;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [23:0]        w_head;

    // Falling edge of the CPU strobe, qualified by the video RAM window.
    assign w_req  = r_prev_n_we & ~cpu_n_we & (cpu_a[15:13] == 3'b111);
    assign w_full = (r_level == C_FULL);
    // The pop happens at the end of HOLD; a pending write may use the slot
    // it frees in the same cycle.
    assign w_pop  = (r_state == S_HOLD);
    assign w_push = r_pend & (~w_full | w_pop);
    assign w_head = r_mem[r_rd_ptr];

    assign n_cpu_wait    = ~(r_pend & w_full & ~w_pop);
    assign level         = r_level;
    assign n_empty       = (r_level != '0);
    assign vbus.bus_a    = n_empty ? w_head[23:8] : 16'h0000;
    assign vbus.bus_d    = n_empty ? w_head[7:0]  : 8'h00;
    assign vbus.bus_n_we = r_bus_n_we;

    // Request capture into the single pending register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev_n_we <= 1'b1;
            r_pend      <= 1'b0;
            r_pend_a    <= 16'h0000;
            r_pend_d    <= 8'h00;
        end else begin
            r_prev_n_we <= cpu_n_we;
            if (w_push) begin
                r_pend <= 1'b0;
            end
            if (w_req) begin
                r_pend   <= 1'b1;
                r_pend_a <= cpu_a;
                r_pend_d <= cpu_d;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted in level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_pend_a, r_pend_d};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Drain sequencer; bus_n_we is registered so it is low only in STROBE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_bus_n_we <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bus_n_we <= 1'b1;
                    if (n_empty) begin
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (!vbus.n_rdy) begin
                        r_state    <= S_STROBE;
                        r_bus_n_we <= 1'b0;
                    end else begin
                        r_bus_n_we <= 1'b1;
                    end
                end
                S_STROBE: begin
                    r_bus_n_we <= 1'b1;
                    // Grant withdrawn during the strobe: the controller gated
                    // the write, so present it again without popping.
                    if (!vbus.n_rdy) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_state <= S_SETUP;
                    end
                end
                S_HOLD: begin
                    r_bus_n_we <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_bus_n_we <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
